mem_tile: RTL and testbench

MEM_TILE -- requirements
Module: mem_tile

---
 rtl/tile_pkg.sv | 30 +++
 rtl/tile_pixel_gen.sv | 59 +++++
 rtl/mem_tile.sv | 55 +++++
 tb/tb_mem_tile.sv | 134 +++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared definitions for the procedural tile ROM.
// Contents:
//   tile_type_e   : 3-bit tile type codes carried in addr[12:10]
//   COL_*         : 24-bit {B,G,R} colour constants used by the pattern generator
//   TILE_ADDR_W   : the only supported address width
package tile_pkg;

    typedef enum logic [2:0] {
        BRICK = 3'b000,
        WALL  = 3'b001,
        TREE  = 3'b010,
        WATER = 3'b011,
        AIR   = 3'b111
    } tile_type_e;

    localparam int unsigned TILE_ADDR_W = 13;

    // {blue, green, red}, 8 bits per channel
    localparam logic [23:0] COL_BRICK_MORTAR = 24'h9C9C9C;
    localparam logic [23:0] COL_BRICK_FACE   = 24'h1040B0;
    localparam logic [23:0] COL_WALL_EDGE    = 24'h606060;
    localparam logic [23:0] COL_WALL_HILITE  = 24'hFFFFFF;
    localparam logic [23:0] COL_WALL_FACE    = 24'hBCBCBC;
    localparam logic [23:0] COL_TREE_LIGHT   = 24'h00A000;
    localparam logic [23:0] COL_TREE_DARK    = 24'h006000;
    localparam logic [23:0] COL_WATER_FOAM   = 24'hFFC0C0;
    localparam logic [23:0] COL_WATER_DEEP   = 24'hE04000;
    localparam logic [23:0] COL_BLACK        = 24'h000000;

endpackage

// File: rtl/tile_pixel_gen.sv
// Combinational pattern generator for the 8 tile types (32x32 pixels each).
// Ports:
//   addr_i   : {tile_type[12:10], y[9:5], x[4:0]}
//   colour_o : 24-bit {B,G,R} pixel colour
module tile_pixel_gen
    import tile_pkg::*;
(
    input  logic [12:0] addr_i,
    output logic [23:0] colour_o
);

    tile_type_e tile;
    logic [4:0] x;
    logic [4:0] y;

    assign tile = tile_type_e'(addr_i[12:10]);
    assign y    = addr_i[9:5];
    assign x    = addr_i[4:0];

    // Every pattern repeats within 16 pixels, so the top bit of x and y is never looked at
    logic unused_xy;
    assign unused_xy = x[4] ^ y[4];

    logic [3:0] mortar_col;
    logic       wall_hilite;

    // Vertical mortar joint shifts by half a brick on alternate 8-pixel courses
    assign mortar_col  = y[3] ? 4'd7 : 4'd15;
    assign wall_hilite = (x[3:0] >= 4'd4) && (x[3:0] <= 4'd11) &&
                         (y[3:0] >= 4'd4) && (y[3:0] <= 4'd11);

    always_comb begin
        colour_o = COL_BLACK;
        case (tile)
            BRICK: begin
                if ((y[2:0] == 3'd7) || (x[3:0] == mortar_col))
                    colour_o = COL_BRICK_MORTAR;
                else
                    colour_o = COL_BRICK_FACE;
            end
            WALL: begin
                if ((x[3:0] == 4'd0) || (y[3:0] == 4'd0))
                    colour_o = COL_WALL_EDGE;
                else if (wall_hilite)
                    colour_o = COL_WALL_HILITE;
                else
                    colour_o = COL_WALL_FACE;
            end
            TREE: begin
                colour_o = (x[2] ^ y[2]) ? COL_TREE_LIGHT : COL_TREE_DARK;
            end
            WATER: begin
                colour_o = ((y[2:0] == 3'd0) && x[1]) ? COL_WATER_FOAM : COL_WATER_DEEP;
            end
            default: colour_o = COL_BLACK;
        endcase
    end

endmodule

// File: rtl/mem_tile.sv
// Read-only procedural tile ROM with a registered output (1-cycle latency).
// Parameters:
//   ADDRESS    : address width, must be 13
//   COLOR_BITS : pixel width, 3*N with N in 1..8; each channel keeps its top N bits
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears dout
//   addr : {tile_type[12:10], y[9:5], x[4:0]}
//   dout : pixel {blue, green, red}, blue in the MSBs
module mem_tile
    import tile_pkg::*;
#(
    parameter int ADDRESS    = 13,
    parameter int COLOR_BITS = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDRESS-1:0]    addr,
    output logic [COLOR_BITS-1:0] dout
);

    localparam int CH_BITS = COLOR_BITS / 3;

    if (ADDRESS != TILE_ADDR_W) begin : g_bad_address
        $error("mem_tile: ADDRESS must be 13");
    end
    if ((COLOR_BITS % 3 != 0) || (CH_BITS < 1) || (CH_BITS > 8)) begin : g_bad_color_bits
        $error("mem_tile: COLOR_BITS must be 3*N with N in 1..8");
    end

    logic [23:0]           colour;
    logic [COLOR_BITS-1:0] dout_d;
    logic [COLOR_BITS-1:0] dout_q;

    tile_pixel_gen u_gen (
        .addr_i   (addr[12:0]),
        .colour_o (colour)
    );

    // Low channel bits are dropped when CH_BITS < 8
    logic [23:0] unused_colour;
    assign unused_colour = colour;

    assign dout_d = {colour[23 -: CH_BITS], colour[15 -: CH_BITS], colour[7 -: CH_BITS]};

    always_ff @(posedge clk) begin
        if (rst)
            dout_q <= '0;
        else
            dout_q <= dout_d;
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_mem_tile.sv
module tb_mem_tile;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] addr;
    logic [23:0] dout24;
    logic [11:0] dout12;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    mem_tile #(.ADDRESS(13), .COLOR_BITS(24)) dut24 (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .dout (dout24)
    );

    mem_tile #(.ADDRESS(13), .COLOR_BITS(12)) dut12 (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .dout (dout12)
    );

    always #5 clk = ~clk;

    // Reference: pixel rules written with plain integer arithmetic on x, y
    function automatic logic [23:0] ref_pixel(input logic [12:0] a);
        int t, x, y, xm, ym;
        t  = int'(a[12:10]);
        y  = int'(a[9:5]);
        x  = int'(a[4:0]);
        xm = x % 16;
        ym = y % 16;
        case (t)
            0: if ((y % 8 == 7) || (xm == (((y / 8) % 2 == 1) ? 7 : 15)))
                   return 24'h9C9C9C;
               else
                   return 24'h1040B0;
            1: if (xm == 0 || ym == 0)
                   return 24'h606060;
               else if (xm >= 4 && xm <= 11 && ym >= 4 && ym <= 11)
                   return 24'hFFFFFF;
               else
                   return 24'hBCBCBC;
            2: return (((x / 4) % 2) != ((y / 4) % 2)) ? 24'h00A000 : 24'h006000;
            3: return ((y % 8 == 0) && ((x / 2) % 2 == 1)) ? 24'hFFC0C0 : 24'hE04000;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [11:0] trunc12(input logic [23:0] c);
        logic [11:0] r;
        r[11:8] = 4'(c[23:16] >> 4);
        r[7:4]  = 4'(c[15:8]  >> 4);
        r[3:0]  = 4'(c[7:0]   >> 4);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present an address, clock it in, then compare both widths just after the edge
    task automatic apply(input logic [12:0] a, input logic r, input string tag);
        logic [23:0] e;
        addr = a;
        rst  = r;
        @(posedge clk);
        #1;
        e = r ? 24'h0 : ref_pixel(a);
        check(tag, 32'(dout24), 32'(e));
        check({tag, "_12"}, 32'(dout12), 32'(trunc12(e)));
    endtask

    initial begin
        int unsigned start;
        int unsigned pulse_at;
        logic [12:0] a;

        rst  = 1'b1;
        addr = 13'h0E3;
        #1;

        for (int i = 0; i < 3; i++) apply(13'h0E3, 1'b1, "reset_hold");
        apply(13'h0E3, 1'b0, "reset_release_0E3");
        check("release_literal", 32'(dout24), 32'h9C9C9C);

        apply(13'h00F, 1'b0, "brick_0F");
        check("brick_0F_lit", 32'(dout24), 32'h9C9C9C);
        apply(13'h025, 1'b0, "brick_025");
        check("brick_025_lit", 32'(dout24), 32'h1040B0);
        check("c12_025_lit", 32'(dout12), 32'h14B);
        apply(13'h10F, 1'b0, "brick_10F");
        check("brick_10F_lit", 32'(dout24), 32'h1040B0);
        apply(13'h4A0, 1'b0, "wall_4A0");
        check("wall_4A0_lit", 32'(dout24), 32'h606060);
        apply(13'h4C6, 1'b0, "wall_4C6");
        check("wall_4C6_lit", 32'(dout24), 32'hFFFFFF);
        apply(13'h4A2, 1'b0, "wall_4A2");
        check("wall_4A2_lit", 32'(dout24), 32'hBCBCBC);
        apply(13'h804, 1'b0, "tree_804");
        check("tree_804_lit", 32'(dout24), 32'h00A000);
        apply(13'hC02, 1'b0, "water_C02");
        check("water_C02_lit", 32'(dout24), 32'hFFC0C0);
        apply(13'hC22, 1'b0, "water_C22");
        check("water_C22_lit", 32'(dout24), 32'hE04000);
        apply(13'h1C00 | 13'($urandom_range(0, 1023)), 1'b0, "air_rand");
        check("air_lit", 32'(dout24), 32'h0);

        // Full sweep from a random start, one address per cycle, with a single-cycle reset pulse
        start    = $urandom_range(0, 8191);
        pulse_at = $urandom_range(1000, 7000);
        for (int unsigned i = 0; i < 8192; i++) begin
            a = 13'((start + i) % 8192);
            apply(a, (i == pulse_at) ? 1'b1 : 1'b0, (i == pulse_at) ? "sweep_rst" : "sweep");
        end

        // Random addresses with occasional resets
        for (int i = 0; i < 1000; i++) begin
            a = 13'($urandom_range(0, 8191));
            apply(a, ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
